// File: rtl/lfsr_encrypt_stage.sv
// LFSR stream encryptor: emits a PRE_CHAR preamble followed by plaintext read from memory,
// each symbol XORed with a 6-bit LFSR keystream, one ciphertext write per clock.
module lfsr_encrypt_stage #(
    parameter int unsigned MSG_LEN  = 64,
    parameter int unsigned PT_BASE  = 0,
    parameter int unsigned CT_BASE  = 64,
    parameter logic [7:0]  PRE_CHAR = 8'h5F,
    parameter int unsigned PRE_MIN  = 7
) (
    input  logic       clk,
    input  logic       init_n,
    input  logic       start,
    input  logic [2:0] tap_sel,
    input  logic [5:0] seed,
    input  logic [3:0] pre_len,
    output logic [7:0] raddr,
    input  logic [7:0] data_out,
    output logic       wr_en,
    output logic [7:0] waddr,
    output logic [7:0] data_in,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [7:0] PT_BASE_B = PT_BASE[7:0];
    localparam logic [7:0] CT_BASE_B = CT_BASE[7:0];
    localparam logic [7:0] LAST_CNT  = 8'(MSG_LEN - 1);
    localparam logic [3:0] PRE_MIN_B = PRE_MIN[3:0];

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    function automatic logic [5:0] tap_pattern(input logic [2:0] sel);
        case (sel)
            3'd0:    tap_pattern = 6'h21;
            3'd1:    tap_pattern = 6'h2D;
            3'd2:    tap_pattern = 6'h30;
            3'd3:    tap_pattern = 6'h33;
            3'd4:    tap_pattern = 6'h36;
            3'd5:    tap_pattern = 6'h39;
            default: tap_pattern = 6'h21;
        endcase
    endfunction

    state_t     state_q;
    logic [5:0] taps_q;
    logic [5:0] lfsr_q;
    logic [3:0] pl_q;
    logic [7:0] cnt_q;
    logic [7:0] raddr_q;
    logic [7:0] waddr_q;
    logic [7:0] data_in_q;
    logic       wr_en_q;
    logic       busy_q;
    logic       done_q;
    logic       err_q;

    logic [7:0] pl_ext_s;
    logic [7:0] cnt_nx_s;
    logic       fb_s;
    logic [5:0] lfsr_d;
    logic       last_s;
    logic [7:0] sym_s;
    logic [7:0] ct_s;
    logic [7:0] raddr_d;
    logic [7:0] data_in_s;

    // Current symbol, ciphertext and next-cycle read address; the read is combinational so
    // the ciphertext byte is formed in the same cycle its plaintext address is presented.
    always_comb begin
        pl_ext_s = {4'd0, pl_q};
        cnt_nx_s = cnt_q + 8'd1;
        fb_s     = ^(lfsr_q & taps_q);
        lfsr_d   = {lfsr_q[4:0], fb_s};
        last_s   = (cnt_q == LAST_CNT);
        if (cnt_q < pl_ext_s) begin
            sym_s = PRE_CHAR;
        end else begin
            sym_s = data_out;
        end
        ct_s = sym_s ^ {2'b00, lfsr_q};
        if (cnt_nx_s < pl_ext_s) begin
            raddr_d = PT_BASE_B;
        end else begin
            raddr_d = PT_BASE_B + cnt_nx_s - pl_ext_s;
        end
        if (state_q == S_RUN) begin
            data_in_s = ct_s;
        end else begin
            data_in_s = data_in_q;
        end
    end

    // Control FSM together with all datapath and output registers.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q   <= S_IDLE;
            taps_q    <= 6'd0;
            lfsr_q    <= 6'd0;
            pl_q      <= 4'd0;
            cnt_q     <= 8'd0;
            raddr_q   <= 8'd0;
            waddr_q   <= 8'd0;
            data_in_q <= 8'd0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    wr_en_q <= 1'b0;
                    done_q  <= 1'b0;
                    raddr_q <= PT_BASE_B;
                    if (start) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    taps_q  <= tap_pattern(tap_sel);
                    lfsr_q  <= (seed == 6'd0) ? 6'h01 : seed;
                    err_q   <= (tap_sel > 3'd5) || (seed == 6'd0);
                    pl_q    <= (pre_len < PRE_MIN_B) ? PRE_MIN_B : pre_len;
                    cnt_q   <= 8'd0;
                    raddr_q <= PT_BASE_B;
                    waddr_q <= CT_BASE_B;
                    wr_en_q <= 1'b1;
                    busy_q  <= 1'b1;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    data_in_q <= ct_s;
                    lfsr_q    <= lfsr_d;
                    cnt_q     <= cnt_nx_s;
                    if (last_s) begin
                        wr_en_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        raddr_q <= PT_BASE_B;
                        state_q <= S_DONE;
                    end else begin
                        waddr_q <= waddr_q + 8'd1;
                        raddr_q <= raddr_d;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    wr_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign raddr   = raddr_q;
    assign wr_en   = wr_en_q;
    assign waddr   = waddr_q;
    assign data_in = data_in_s;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_lfsr_encrypt_stage.sv
// Randomized bench for lfsr_encrypt_stage: a behavioural keystream/message model predicts
// every ciphertext byte, the run timing, err behaviour and the decryptor round trip.
module tb_lfsr_encrypt_stage;

    localparam int MSG_LEN = 64;

    logic       clk = 1'b0;
    logic       init_n;
    logic       start;
    logic [2:0] tap_sel;
    logic [5:0] seed;
    logic [3:0] pre_len;
    logic [7:0] raddr;
    logic [7:0] data_out;
    logic       wr_en;
    logic [7:0] waddr;
    logic [7:0] data_in;
    logic       busy;
    logic       done;
    logic       err;

    logic [7:0] pt_mem [256];
    logic [7:0] ct_mem [256];
    int         stamp [256];
    int         run_id = 0;
    int         wr_total = 0;
    int         oob_total = 0;

    int         n_tests = 0;
    int         n_fail = 0;

    int         pats [6] = '{32'h21, 32'h2D, 32'h30, 32'h33, 32'h36, 32'h39};
    logic [7:0] exp_ct [MSG_LEN];
    int         exp_ks [MSG_LEN];
    int         exp_pl;
    logic       exp_err;

    int         lat, first_wr, ndone, busy_bad, wr_base, oob_base;
    logic       err_done;

    always #5 clk = ~clk;

    lfsr_encrypt_stage dut (
        .clk(clk), .init_n(init_n), .start(start), .tap_sel(tap_sel), .seed(seed),
        .pre_len(pre_len), .raddr(raddr), .data_out(data_out), .wr_en(wr_en),
        .waddr(waddr), .data_in(data_in), .busy(busy), .done(done), .err(err)
    );

    assign data_out = pt_mem[raddr];

    // Ciphertext memory plus write bookkeeping.
    always @(posedge clk) begin
        if (wr_en) begin
            ct_mem[waddr] <= data_in;
            stamp[waddr]  <= run_id;
            wr_total      <= wr_total + 1;
            if (waddr < 8'd64 || waddr > 8'd127) oob_total <= oob_total + 1;
        end
    end

    task automatic fill_pt();
        for (int i = 0; i < 256; i++) pt_mem[i] = 8'($urandom);
    endtask

    // Message = pl preamble chars then plaintext, XOR keystream from the LFSR recurrence.
    task automatic model(input int tap, input int sd, input int pre);
        int taps, ks, sym;
        taps    = (tap < 6) ? pats[tap] : 32'h21;
        ks      = (sd == 0) ? 1 : sd;
        exp_pl  = (pre < 7) ? 7 : pre;
        exp_err = (tap > 5) || (sd == 0);
        for (int i = 0; i < MSG_LEN; i++) begin
            sym       = (i < exp_pl) ? 32'h5F : int'(pt_mem[i - exp_pl]);
            exp_ks[i] = ks;
            exp_ct[i] = 8'(sym ^ ks);
            ks        = ((ks * 2) + ($countones(ks & taps) % 2)) % 64;
        end
    endtask

    task automatic run_dut(input int tap, input int sd, input int pre, input int pulse_at);
        run_id = run_id + 1;
        @(negedge clk);
        tap_sel = 3'(tap); seed = 6'(sd); pre_len = 4'(pre); start = 1'b1;
        lat = -1; first_wr = -1; ndone = 0; busy_bad = 0; err_done = 1'bx;
        wr_base = wr_total; oob_base = oob_total;
        for (int n = 1; n <= MSG_LEN + 10; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (pulse_at > 0 && n == pulse_at) begin
                start = 1'b1; tap_sel = 3'($urandom_range(0, 7));
                seed = 6'($urandom); pre_len = 4'($urandom);
            end else if (pulse_at > 0 && n == pulse_at + 1) begin
                start = 1'b0;
            end
            if (wr_en === 1'b1 && first_wr < 0) first_wr = n;
            if (done === 1'b1) begin
                ndone++;
                if (lat < 0) begin lat = n; err_done = err; end
            end
            if (busy !== (n <= MSG_LEN + 1)) busy_bad++;
        end
    endtask

    function automatic int ct_bad();
        int bad = 0;
        for (int i = 0; i < MSG_LEN; i++)
            if (ct_mem[64 + i] !== exp_ct[i] || stamp[64 + i] != run_id) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        init_n = 1'b0; start = 1'b0; tap_sel = 3'd0; seed = 6'd0; pre_len = 4'd0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({wr_en, waddr, raddr, data_in, busy, done, err} !== 28'd0) begin
            n_fail++; $display("FAIL reset_outputs got %h want 0", {wr_en, waddr, raddr, data_in, busy, done, err});
        end
        init_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({wr_en, busy, done, err} !== 4'd0) begin
            n_fail++; $display("FAIL idle_after_reset got %b want 0000", {wr_en, busy, done, err});
        end
    endtask

    task automatic test_vector();
        fill_pt();
        model(0, 1, 7);
        run_dut(0, 1, 7, 0);
        n_tests++;
        if ({ct_mem[64], ct_mem[65], ct_mem[66]} !== 24'h5E5C58) begin
            n_fail++; $display("FAIL vector_first3 got %h want 5e5c58", {ct_mem[64], ct_mem[65], ct_mem[66]});
        end
        n_tests++;
        if (ct_mem[71] !== (pt_mem[0] ^ 8'(exp_ks[7]))) begin
            n_fail++; $display("FAIL vector_mem71 got %h want %h", ct_mem[71], pt_mem[0] ^ 8'(exp_ks[7]));
        end
        n_tests++;
        if (ct_bad() != 0) begin n_fail++; $display("FAIL vector_all got %0d bad bytes want 0", ct_bad()); end
        n_tests++;
        if (first_wr != 2 || lat != MSG_LEN + 2) begin
            n_fail++; $display("FAIL vector_timing got first_wr=%0d done=%0d want 2 %0d", first_wr, lat, MSG_LEN + 2);
        end
    endtask

    task automatic test_all_taps();
        int sd, pre, bad_dec;
        for (int t = 0; t < 6; t++) begin
            fill_pt();
            sd  = $urandom_range(1, 63);
            pre = $urandom_range(7, 12);
            model(t, sd, pre);
            run_dut(t, sd, pre, 0);
            n_tests++;
            if (ct_bad() != 0) begin n_fail++; $display("FAIL taps%0d_ct got %0d bad bytes want 0", t, ct_bad()); end
            n_tests++;
            if (lat != MSG_LEN + 2 || ndone != 1) begin
                n_fail++; $display("FAIL taps%0d_done got lat=%0d pulses=%0d want %0d 1", t, lat, ndone, MSG_LEN + 2);
            end
            n_tests++;
            if (wr_total - wr_base != MSG_LEN || oob_total != oob_base) begin
                n_fail++; $display("FAIL taps%0d_writes got %0d oob=%0d want %0d 0", t, wr_total - wr_base, oob_total - oob_base, MSG_LEN);
            end
            n_tests++;
            if (busy_bad != 0 || err_done !== 1'b0) begin
                n_fail++; $display("FAIL taps%0d_busy_err got busy_bad=%0d err=%b want 0 0", t, busy_bad, err_done);
            end
            // Downstream decryptor: strip keystream and preamble, recover plaintext.
            bad_dec = 0;
            for (int i = 0; i < MSG_LEN; i++) begin
                if (i < exp_pl) begin
                    if ((ct_mem[64 + i] ^ 8'(exp_ks[i])) !== 8'h5F) bad_dec++;
                end else if ((ct_mem[64 + i] ^ 8'(exp_ks[i])) !== pt_mem[i - exp_pl]) begin
                    bad_dec++;
                end
            end
            n_tests++;
            if (bad_dec != 0) begin n_fail++; $display("FAIL taps%0d_decrypt got %0d bad want 0", t, bad_dec); end
        end
    endtask

    task automatic test_short_preamble();
        fill_pt();
        model(2, 0, 3);
        run_dut(2, 0, 3, 0);
        n_tests++;
        if (ct_bad() != 0 || (ct_mem[64] ^ 8'h5F) !== 8'h01) begin
            n_fail++; $display("FAIL short_pre_ct got %0d bad, ks0=%h want 0 01", ct_bad(), ct_mem[64] ^ 8'h5F);
        end
        n_tests++;
        if (err_done !== 1'b1 || err !== 1'b1) begin
            n_fail++; $display("FAIL short_pre_err got %b/%b want 1/1", err_done, err);
        end
        fill_pt();
        model(1, 9, 8);
        run_dut(1, 9, 8, 0);
        n_tests++;
        if (err_done !== 1'b0 || ct_bad() != 0) begin
            n_fail++; $display("FAIL clean_after_err got err=%b bad=%0d want 0 0", err_done, ct_bad());
        end
    endtask

    task automatic test_bad_tap();
        logic [7:0] save [MSG_LEN];
        int sd, pre;
        fill_pt();
        sd = $urandom_range(1, 63); pre = $urandom_range(7, 12);
        model(6, sd, pre);
        run_dut(6, sd, pre, 0);
        for (int i = 0; i < MSG_LEN; i++) save[i] = ct_mem[64 + i];
        n_tests++;
        if (ct_bad() != 0 || err_done !== 1'b1) begin
            n_fail++; $display("FAIL bad_tap got bad=%0d err=%b want 0 1", ct_bad(), err_done);
        end
        run_dut(0, sd, pre, 0);
        n_tests++;
        if (save != ct_mem[64:127] || err_done !== 1'b0) begin
            n_fail++; $display("FAIL bad_tap_vs_tap0 got differing output or err=%b want identical 0", err_done);
        end
    endtask

    task automatic test_start_midrun();
        fill_pt();
        model(4, 21, 10);
        run_dut(4, 21, 10, 30);
        n_tests++;
        if (ndone != 1 || lat != MSG_LEN + 2 || ct_bad() != 0 || wr_total - wr_base != MSG_LEN) begin
            n_fail++; $display("FAIL start_midrun got pulses=%0d lat=%0d bad=%0d writes=%0d want 1 %0d 0 %0d",
                               ndone, lat, ct_bad(), wr_total - wr_base, MSG_LEN + 2, MSG_LEN);
        end
    endtask

    task automatic test_reset_midrun();
        bit found = 1'b0;
        int base;
        fill_pt();
        run_id = run_id + 1;
        @(negedge clk);
        tap_sel = 3'd3; seed = 6'd17; pre_len = 4'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if (wr_en === 1'b1 && waddr === 8'd84) found = 1'b1;
        end
        n_tests++;
        if (!found) begin n_fail++; $display("FAIL reach_cnt20 got timeout want write at 84"); end
        init_n = 1'b0;
        #1;
        n_tests++;
        if ({wr_en, waddr, raddr, data_in, busy, done, err} !== 28'd0) begin
            n_fail++; $display("FAIL reset_midrun got %h want 0", {wr_en, waddr, raddr, data_in, busy, done, err});
        end
        base = wr_total;
        repeat (3) @(negedge clk);
        n_tests++;
        if (wr_total != base || wr_en !== 1'b0) begin
            n_fail++; $display("FAIL writes_in_reset got %0d wr_en=%b want 0 0", wr_total - base, wr_en);
        end
        init_n = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || wr_en !== 1'b0) begin
            n_fail++; $display("FAIL no_restart got busy=%b wr_en=%b want 0 0", busy, wr_en);
        end
        model(3, 17, 9);
        run_dut(3, 17, 9, 0);
        n_tests++;
        if (ct_bad() != 0 || lat != MSG_LEN + 2 || ndone != 1) begin
            n_fail++; $display("FAIL run_after_reset got bad=%0d lat=%0d pulses=%0d want 0 %0d 1", ct_bad(), lat, ndone, MSG_LEN + 2);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) pt_mem[i] = 8'd0;
        test_reset();
        test_vector();
        test_all_taps();
        test_short_preamble();
        test_bad_tap();
        test_start_midrun();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
